// File: rtl/stopwatch_key_ctrl_if.sv
// rtl/stopwatch_key_ctrl_if.sv - key inputs and control outputs of the stopwatch front end
interface stopwatch_key_ctrl_if;
   logic       key_start_n;
   logic       key_clear_n;
   logic       run;
   logic       clear_n;
   logic       start_press;
   logic       clear_press;
   logic [1:0] state_dbg;

   modport master (
      output key_start_n,
      output key_clear_n,
      input  run,
      input  clear_n,
      input  start_press,
      input  clear_press,
      input  state_dbg
   );

   modport slave (
      input  key_start_n,
      input  key_clear_n,
      output run,
      output clear_n,
      output start_press,
      output clear_press,
      output state_dbg
   );
endinterface

// File: rtl/stopwatch_key_ctrl.sv
// rtl/stopwatch_key_ctrl.sv - key synchronizer/debouncer and run/pause/clear FSM
module stopwatch_key_ctrl #(
   parameter int DEBOUNCE_CYCLES = 1000000,
   parameter int CNT_W           = 20,
   parameter int CLEAR_CYCLES    = 2
) (
   input  logic               CLOCK_50,
   input  logic               resetn,
   stopwatch_key_ctrl_if.slave sw
);

   typedef enum logic [1:0] {
      IDLE    = 2'b00,
      RUNNING = 2'b01,
      PAUSED  = 2'b10
   } state_t;

   localparam int              CLR_W    = $clog2(CLEAR_CYCLES + 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
   localparam logic [CLR_W-1:0] CLR_LOAD = CLR_W'(CLEAR_CYCLES);

   // Bit 0 is the start/stop key, bit 1 the clear key.
   logic [1:0]       raw;
   logic [1:0]       sync1;
   logic [1:0]       sync2;
   logic [1:0]       deb;
   logic [1:0]       deb_d;
   logic [1:0]       fall;
   logic [CNT_W-1:0] cnt [2];

   logic             start_fall;
   logic             clear_fall;
   logic             start_press_q;
   logic             clear_press_q;

   state_t           state;
   state_t           state_nxt;
   logic             run_q;
   logic             run_nxt;
   logic [CLR_W-1:0] clr_cnt;
   logic [CLR_W-1:0] clr_cnt_nxt;

   assign raw = {sw.key_clear_n, sw.key_start_n};

   always_ff @(posedge CLOCK_50 or negedge resetn) begin
      if (!resetn) begin
         sync1 <= 2'b11;
         sync2 <= 2'b11;
         deb   <= 2'b11;
         deb_d <= 2'b11;
         for (int k = 0; k < 2; k++) begin
            cnt[k] <= '0;
         end
      end else begin
         sync1 <= raw;
         sync2 <= sync1;
         deb_d <= deb;
         for (int k = 0; k < 2; k++) begin
            if (sync2[k] == deb[k]) begin
               cnt[k] <= '0;
            end else if (cnt[k] == CNT_LAST) begin
               deb[k] <= sync2[k];
               cnt[k] <= '0;
            end else begin
               cnt[k] <= cnt[k] + 1'b1;
            end
         end
      end
   end

   // A press is a debounced 1->0 step; it drives the FSM in the same cycle it is registered as a pulse.
   assign fall       = deb_d & ~deb;
   assign start_fall = fall[0];
   assign clear_fall = fall[1];

   always_ff @(posedge CLOCK_50 or negedge resetn) begin
      if (!resetn) begin
         state         <= IDLE;
         run_q         <= 1'b0;
         clr_cnt       <= '0;
         start_press_q <= 1'b0;
         clear_press_q <= 1'b0;
      end else begin
         state         <= state_nxt;
         run_q         <= run_nxt;
         clr_cnt       <= clr_cnt_nxt;
         start_press_q <= start_fall;
         clear_press_q <= clear_fall;
      end
   end

   always_comb begin
      state_nxt   = state;
      clr_cnt_nxt = clr_cnt;
      if (clear_fall) begin
         clr_cnt_nxt = CLR_LOAD;
      end else if (clr_cnt != '0) begin
         clr_cnt_nxt = clr_cnt - 1'b1;
      end

      // Clear wins over start; start is also ignored while the clear pulse is still low.
      if (clear_fall) begin
         state_nxt = IDLE;
      end else if (start_fall && (clr_cnt_nxt == '0)) begin
         case (state)
            IDLE:    state_nxt = RUNNING;
            RUNNING: state_nxt = PAUSED;
            PAUSED:  state_nxt = RUNNING;
            default: state_nxt = IDLE;
         endcase
      end

      run_nxt = (state_nxt == RUNNING);
   end

   assign sw.run         = run_q;
   assign sw.clear_n     = (clr_cnt == '0);
   assign sw.start_press = start_press_q;
   assign sw.clear_press = clear_press_q;
   assign sw.state_dbg   = state;

endmodule

// File: tb/tb_stopwatch_key_ctrl.sv
// tb/tb_stopwatch_key_ctrl.sv - directed bench for stopwatch_key_ctrl
module tb_stopwatch_key_ctrl;

   logic clk;
   logic resetn;
   int   total;
   int   bad;
   int   sp_seen;
   int   cp_seen;
   int   clr_low_seen;

   stopwatch_key_ctrl_if sw ();

   stopwatch_key_ctrl #(
      .DEBOUNCE_CYCLES(4),
      .CNT_W          (3),
      .CLEAR_CYCLES   (2)
   ) dut (
      .CLOCK_50(clk),
      .resetn  (resetn),
      .sw      (sw.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
      end
   endtask

   // Set both keys, then advance n edges, sampling 1 time unit after each edge.
   task automatic drive(input logic s, input logic c, input int n);
      sw.key_start_n = s;
      sw.key_clear_n = c;
      for (int i = 0; i < n; i++) begin
         @(posedge clk);
         #1;
         if (sw.start_press) sp_seen++;
         if (sw.clear_press) cp_seen++;
         if (!sw.clear_n) clr_low_seen++;
      end
   endtask

   task automatic clr_seen();
      sp_seen      = 0;
      cp_seen      = 0;
      clr_low_seen = 0;
   endtask

   initial begin
      total  = 0;
      bad    = 0;
      resetn = 1'b0;
      sw.key_start_n = 1'b1;
      sw.key_clear_n = 1'b1;
      clr_seen();

      // Reset held with keys toggling
      for (int i = 0; i < 6; i++) begin
         drive(i[0], ~i[0], 1);
         chk("rst_run", sw.run, 0);
         chk("rst_clear_n", sw.clear_n, 1);
         chk("rst_pulses", {sw.start_press, sw.clear_press}, 0);
         chk("rst_state", sw.state_dbg, 0);
      end
      drive(1, 1, 1);
      resetn = 1'b1;
      drive(1, 1, 8);
      chk("idle_state", sw.state_dbg, 0);

      // Start press latency: pulse after the 7th sampled edge (edge 6)
      clr_seen();
      drive(0, 1, 6);
      chk("start_early", sp_seen, 0);
      chk("start_early_run", sw.run, 0);
      drive(0, 1, 1);
      chk("start_pulse", sw.start_press, 1);
      chk("start_run", sw.run, 1);
      chk("start_state", sw.state_dbg, 1);
      drive(0, 1, 1);
      chk("start_pulse_width", sw.start_press, 0);
      drive(0, 1, 12);
      chk("start_hold_one", sp_seen, 1);
      clr_seen();
      drive(1, 1, 10);
      chk("release_no_pulse", sp_seen, 0);

      // Toggle RUNNING -> PAUSED -> RUNNING
      drive(0, 1, 10);
      chk("toggle_pause_state", sw.state_dbg, 2);
      chk("toggle_pause_run", sw.run, 0);
      drive(1, 1, 10);
      drive(0, 1, 10);
      chk("toggle_resume_state", sw.state_dbg, 1);
      chk("toggle_resume_run", sw.run, 1);
      drive(1, 1, 10);

      // Clear and start on the same sampled edge while RUNNING
      clr_seen();
      drive(0, 0, 6);
      chk("both_early", cp_seen + sp_seen, 0);
      drive(0, 0, 1);
      chk("both_clear_press", sw.clear_press, 1);
      chk("both_start_press", sw.start_press, 1);
      chk("both_state", sw.state_dbg, 0);
      chk("both_run", sw.run, 0);
      chk("both_clear_n0", sw.clear_n, 0);
      drive(0, 0, 1);
      chk("both_clear_n1", sw.clear_n, 0);
      chk("both_run1", sw.run, 0);
      drive(0, 0, 1);
      chk("both_clear_n2", sw.clear_n, 1);
      drive(0, 0, 8);
      chk("both_clear_len", clr_low_seen, 2);
      chk("both_state_after", sw.state_dbg, 0);
      drive(1, 1, 10);

      // Bounce: 3 low, 1 high, 3 low never accepted
      clr_seen();
      drive(0, 1, 3);
      drive(1, 1, 1);
      drive(0, 1, 3);
      drive(1, 1, 10);
      chk("bounce_no_pulse", sp_seen, 0);
      chk("bounce_run", sw.run, 0);
      drive(0, 1, 10);
      chk("bounce_hold_one", sp_seen, 1);
      chk("bounce_state", sw.state_dbg, 1);
      drive(1, 1, 10);

      // Reset during the first clear_n low cycle
      clr_seen();
      drive(1, 0, 7);
      chk("midclr_low", sw.clear_n, 0);
      chk("midclr_state", sw.state_dbg, 0);
      resetn = 1'b0;
      #1;
      chk("midclr_async", sw.clear_n, 1);
      chk("midclr_async_press", sw.clear_press, 0);
      drive(1, 1, 3);
      resetn = 1'b1;
      clr_seen();
      drive(1, 1, 15);
      chk("midclr_no_pulses", sp_seen + cp_seen, 0);
      chk("midclr_no_low", clr_low_seen, 0);
      chk("midclr_state_end", sw.state_dbg, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
